// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a client and the serial adder.
interface serial_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output start, SUB, A, B,
        input  S, C, V, busy, done
    );

    modport slave (
        input  start, SUB, A, B,
        output S, C, V, busy, done
    );

endinterface

// File: rtl/full_adder.sv
// Full-adder slice built from two half adders and an OR of their carries.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .A (A),
        .B (B),
        .S (w_s0),
        .C (w_c0)
    );

    half_adder u_ha1 (
        .A (w_s0),
        .B (Cin),
        .S (S),
        .C (w_c1)
    );

    assign Cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two inputs.
module half_adder (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);

    assign S = A ^ B;
    assign C = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first, WIDTH cycles
// per operation, registered S/C/V published with a one-cycle done pulse.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;
    logic             r_busy;
    logic             r_done;

    logic             w_sum;
    logic             w_cout;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_acc_next;

    full_adder u_fa (
        .A    (r_sa[0]),
        .B    (r_sb[0]),
        .Cin  (r_carry),
        .S    (w_sum),
        .Cout (w_cout)
    );

    assign w_last     = (r_state == RUN) && (r_cnt == LAST_CNT);
    assign w_load     = (w_next == RUN) && (r_state != RUN);
    // Sum bits enter at the top; after WIDTH shifts the first bit lands in S[0].
    assign w_acc_next = {w_sum, r_acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = bus.start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_next == RUN);
            r_done <= (w_next == DONE);
            if (w_load) begin
                // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                r_sa    <= bus.A;
                r_sb    <= bus.SUB ? ~bus.B : bus.B;
                r_carry <= bus.SUB;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_sa    <= r_sa >> 1;
                r_sb    <= r_sb >> 1;
                r_carry <= w_cout;
                r_acc   <= w_acc_next[WIDTH-1:1];
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_s <= w_acc_next;
                    r_c <= w_cout;
                    r_v <= r_carry ^ w_cout;
                end
            end
        end
    end

    assign bus.S    = r_s;
    assign bus.C    = r_c;
    assign bus.V    = r_v;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder against an arithmetic reference.
module tb_serial_adder;
    import adder_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] s, output logic c, output logic v);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = sub ? (ua - ub) : (ua + ub);
        sr = sub ? (sa - sb) : (sa + sb);
        s  = W'(ur);
        c  = sub ? (ua >= ub) : (ur > 255);
        v  = (sr > 127) || (sr < -128);
    endtask

    task automatic wait_done(output int cyc, output bit seen, output int s_changes);
        logic [W-1:0] s0;
        s0        = bus.S;
        cyc       = 0;
        seen      = 1'b0;
        s_changes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.S !== s0) s_changes++;
            if (bus.busy !== 1'b1) s_changes++;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub);
        logic [W-1:0] es;
        logic         ec, ev;
        model(a, b, sub, es, ec, ev);
        chk({tag, "_S"}, 32'(bus.S), 32'(es));
        chk({tag, "_C"}, 32'(bus.C), 32'(ec));
        chk({tag, "_V"}, 32'(bus.V), 32'(ev));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub);
        int cyc, sch;
        bit seen;
        bus.A     = a;
        bus.B     = b;
        bus.SUB   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.SUB   = ~sub;
        chk({tag, "_busy_after_start"}, 32'(bus.busy), 1);
        wait_done(cyc, seen, sch);
        chk({tag, "_latency"}, cyc, W);
        chk({tag, "_no_partial"}, sch, 0);
        check_result(tag, a, b, sub);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 0);
    endtask

    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) n++;
        end
    endtask

    initial begin
        int           cyc, sch, nd;
        bit           seen;
        logic [W-1:0] ra, rb;
        logic         rs;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.SUB   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        chk("rst_S", 32'(bus.S), 0);
        chk("rst_C", 32'(bus.C), 0);
        chk("rst_V", 32'(bus.V), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
        run_op("sub_eq",    8'h3C, 8'h3C, 1'b1);

        // A start pulse in the middle of RUN must be ignored.
        bus.A = 8'h03; bus.B = 8'h04; bus.SUB = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        bus.A = 8'hAA; bus.B = 8'h55; bus.SUB = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, seen, sch);
        chk("ignore_latency", cyc + 4, W);
        check_result("ignore", 8'h03, 8'h04, 1'b0);
        count_done(12, nd);
        chk("ignore_single_done", nd, 0);

        // Back-to-back: start held high through the DONE cycle.
        bus.A = 8'h12; bus.B = 8'h34; bus.SUB = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.A = 8'h50; bus.B = 8'h20; bus.SUB = 1'b1;
        wait_done(cyc, seen, sch);
        chk("b2b_first_latency", cyc, W);
        check_result("b2b_first", 8'h12, 8'h34, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_rebusy", 32'(bus.busy), 1);
        chk("b2b_done_drop", 32'(bus.done), 0);
        wait_done(cyc, seen, sch);
        chk("b2b_second_latency", cyc, W);
        check_result("b2b_second", 8'h50, 8'h20, 1'b1);
        @(posedge clk);
        #1;

        // Mid-run asynchronous reset: outputs clear before any clock edge.
        run_op("pre_rst", 8'hF0, 8'h30, 1'b0);
        bus.A = 8'h5A; bus.B = 8'h3C; bus.SUB = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_S", 32'(bus.S), 0);
        chk("arst_C", 32'(bus.C), 0);
        chk("arst_V", 32'(bus.V), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_done(14, nd);
        chk("arst_no_done", nd, 0);
        chk("arst_idle_busy", 32'(bus.busy), 0);
        run_op("post_rst", 8'h5A, 8'h3C, 1'b0);

        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", k), ra, rb, rs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
